// File: rtl/ov7670_pixel_capture.sv
// ============================================================================
// Module   : ov7670_pixel_capture
// Purpose  : Assembles OV7670 RGB565 byte pairs into {sof, pixel} queue words
//            and checks each frame's line/row geometry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ov7670_pixel_capture #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  pixel_data,
    input  logic        queue_full,
    output logic        queue_wr_en,
    output logic [16:0] queue_data,
    output logic        frame_done,
    output logic        frame_error,
    output logic        overflow,
    output logic [15:0] frame_count
);

    localparam logic [10:0] WIDTH_C  = 11'(FRAME_WIDTH);
    localparam logic [10:0] HEIGHT_C = 11'(FRAME_HEIGHT);
    localparam logic [10:0] CNT_MAX  = 11'd2047;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_BLANK = 3'd1,
        WAIT_START = 3'd2,
        CAPTURE    = 3'd3,
        FRAME_END  = 3'd4
    } state_t;

    state_t      state;
    logic [10:0] row;
    logic [10:0] col;
    logic        phase;
    logic [7:0]  hi_byte;
    logic        href_prev;
    logic        line_bad;
    logic        sof_pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            phase       <= 1'b0;
            hi_byte     <= '0;
            href_prev   <= 1'b0;
            line_bad    <= 1'b0;
            sof_pending <= 1'b0;
            queue_wr_en <= 1'b0;
            queue_data  <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            overflow    <= 1'b0;
            frame_count <= '0;
        end else begin
            queue_wr_en <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            href_prev   <= href;

            // Disabling always wins: any half-assembled pixel is thrown away.
            if (!enable) begin
                state <= IDLE;
                phase <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= WAIT_BLANK;

                    WAIT_BLANK: begin
                        if (vsync) state <= WAIT_START;
                    end

                    WAIT_START: begin
                        if (!vsync) begin
                            state       <= CAPTURE;
                            row         <= '0;
                            col         <= '0;
                            phase       <= 1'b0;
                            line_bad    <= 1'b0;
                            overflow    <= 1'b0;
                            sof_pending <= 1'b1;
                        end
                    end

                    CAPTURE: begin
                        if (href) begin
                            if (!phase) begin
                                hi_byte <= pixel_data;
                                phase   <= 1'b1;
                            end else begin
                                phase <= 1'b0;
                                if (col != CNT_MAX) col <= col + 11'd1;
                                if (!queue_full) begin
                                    queue_wr_en <= 1'b1;
                                    queue_data  <= {sof_pending, hi_byte, pixel_data};
                                    sof_pending <= 1'b0;
                                end else begin
                                    overflow <= 1'b1;
                                end
                            end
                        end else if (href_prev) begin
                            if ((col != WIDTH_C) || phase) line_bad <= 1'b1;
                            if (row != CNT_MAX) row <= row + 11'd1;
                            col   <= '0;
                            phase <= 1'b0;
                        end
                        // Byte and line-end work above still completes in the vsync-rise cycle.
                        if (vsync) state <= FRAME_END;
                    end

                    FRAME_END: begin
                        if ((row == HEIGHT_C) && !line_bad) begin
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                        state <= WAIT_START;
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ov7670_pixel_capture.sv
// Self-checking bench for ov7670_pixel_capture: frames are described as line
// byte counts and checked against a pixel/geometry model built from those counts.
`timescale 1ns/1ps
`default_nettype none

module tb_ov7670_pixel_capture;

    localparam int W = 2;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  pixel_data = 8'h00;
    logic        queue_full = 1'b0;
    logic        queue_wr_en;
    logic [16:0] queue_data;
    logic        frame_done;
    logic        frame_error;
    logic        overflow;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_fail = 0;
    int exp_fc = 0;

    logic [16:0] act_q[$];
    int done_cnt = 0;
    int err_cnt = 0;

    ov7670_pixel_capture #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .vsync       (vsync),
        .href        (href),
        .pixel_data  (pixel_data),
        .queue_full  (queue_full),
        .queue_wr_en (queue_wr_en),
        .queue_data  (queue_data),
        .frame_done  (frame_done),
        .frame_error (frame_error),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (reset_n) begin
            if (queue_wr_en) act_q.push_back(queue_data);
            if (frame_done)  done_cnt++;
            if (frame_error) err_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc(input logic v, input logic h, input logic [7:0] d, input logic f);
        @(negedge clk);
        vsync = v; href = h; pixel_data = d; queue_full = f;
    endtask

    // Drives one full frame (blanking, lines, closing blanking) and checks it.
    // tail: 0 = gap before vsync, 1 = vsync rises as href falls, 2 = vsync rises with last byte.
    task automatic run_frame(input int nlines, input int l0, input int l1, input int l2,
                             input int tail, input int full_pct, input bit fixed,
                             input bit full_first, input string name);
        int          lens[3];
        logic [7:0]  pat[4];
        logic [16:0] exp_q[$];
        logic [7:0]  hi, b;
        logic        f, v;
        bit          sof, ovf, bad, exp_done;
        int          rows, pix, a0, d0, e0, nact;
        lens[0] = l0; lens[1] = l1; lens[2] = l2;
        pat[0] = 8'h12; pat[1] = 8'h34; pat[2] = 8'h56; pat[3] = 8'h78;
        sof = 1'b1; ovf = 1'b0; bad = 1'b0; rows = 0; pix = 0; hi = 8'h00;
        a0 = act_q.size(); d0 = done_cnt; e0 = err_cnt;

        repeat (3) cyc(1'b1, 1'b0, 8'($urandom), 1'($urandom));
        repeat (2) cyc(1'b0, 1'b0, 8'($urandom), 1'($urandom));
        for (int l = 0; l < nlines; l++) begin
            for (int k = 0; k < lens[l]; k++) begin
                b = fixed ? pat[k % 4] : 8'($urandom);
                f = 1'($urandom);
                if (k % 2 == 1) begin
                    f = (full_first && pix == 0) || ($urandom_range(99) < full_pct);
                    if (f) ovf = 1'b1;
                    else begin
                        exp_q.push_back({sof, hi, b});
                        sof = 1'b0;
                    end
                    pix++;
                end else begin
                    hi = b;
                end
                v = (tail == 2) && (l == nlines - 1) && (k == lens[l] - 1);
                cyc(v, 1'b1, b, f);
            end
            if (!(tail == 2 && l == nlines - 1)) begin
                rows++;
                if (lens[l] != 2 * W) bad = 1'b1;
            end
            if (!(l == nlines - 1 && tail != 0))
                repeat (2) cyc(1'b0, 1'b0, 8'($urandom), 1'($urandom));
        end
        repeat (5) cyc(1'b1, 1'b0, 8'($urandom), 1'($urandom));

        exp_done = (rows == H) && !bad;
        if (exp_done) exp_fc++;
        nact = act_q.size() - a0;

        n_checks++;
        if (nact !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d expected %0d", name, nact, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < nact; i++) begin
            n_checks++;
            if (act_q[a0 + i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s word[%0d]: got %05h expected %05h", name, i, act_q[a0 + i], exp_q[i]);
            end
        end
        n_checks++;
        if ((done_cnt - d0) !== (exp_done ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s frame_done_pulses: got %0d expected %0d", name, done_cnt - d0, exp_done ? 1 : 0);
        end
        n_checks++;
        if ((err_cnt - e0) !== (exp_done ? 0 : 1)) begin
            n_fail++;
            $display("FAIL %s frame_error_pulses: got %0d expected %0d", name, err_cnt - e0, exp_done ? 0 : 1);
        end
        n_checks++;
        if (frame_count !== 16'(exp_fc)) begin
            n_fail++;
            $display("FAIL %s frame_count: got %0d expected %0d", name, frame_count, exp_fc);
        end
        n_checks++;
        if (overflow !== ovf) begin
            n_fail++;
            $display("FAIL %s overflow: got %0b expected %0b", name, overflow, ovf);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 8'hA5, 1'b0);
        n_checks++;
        if ({queue_wr_en, queue_data, frame_done, frame_error, overflow, frame_count} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wr=%0b data=%05h done=%0b err=%0b ovf=%0b fc=%0d expected all 0",
                     queue_wr_en, queue_data, frame_done, frame_error, overflow, frame_count);
        end
        reset_n = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0);
        n_checks++;
        if ({queue_wr_en, frame_done, frame_error, frame_count} !== 19'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got wr=%0b done=%0b err=%0b fc=%0d expected 0",
                     queue_wr_en, frame_done, frame_error, frame_count);
        end
    endtask

    task automatic test_basic_frame();
        logic [16:0] lit[4];
        int a0;
        lit[0] = 17'h11234; lit[1] = 17'h05678; lit[2] = 17'h01234; lit[3] = 17'h05678;
        a0 = act_q.size();
        run_frame(2, 4, 4, 0, 0, 0, 1'b1, 1'b0, "basic");
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (act_q.size() <= a0 + i || act_q[a0 + i] !== lit[i]) begin
                n_fail++;
                $display("FAIL basic_literal[%0d]: got %05h expected %05h", i,
                         (act_q.size() > a0 + i) ? act_q[a0 + i] : 17'h0, lit[i]);
            end
        end
    endtask

    task automatic test_enable_mid_frame();
        int a0, d0, e0;
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        enable = 1'b0;
        repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b0);
        a0 = act_q.size(); d0 = done_cnt; e0 = err_cnt;
        repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b0);
        for (int l = 0; l < 2; l++) begin
            for (int k = 0; k < 4; k++) begin
                cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
                if (l == 0 && k == 1) enable = 1'b1;
            end
            repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b0);
        end
        repeat (5) cyc(1'b1, 1'b0, 8'h00, 1'b0);
        n_checks++;
        if (act_q.size() != a0 || done_cnt != d0 || err_cnt != e0) begin
            n_fail++;
            $display("FAIL midframe_enable_quiet: got writes=%0d pulses=%0d expected 0 and 0",
                     act_q.size() - a0, (done_cnt - d0) + (err_cnt - e0));
        end
        a0 = act_q.size();
        run_frame(2, 4, 4, 0, 0, 0, 1'b0, 1'b0, "after_enable");
        n_checks++;
        if (act_q.size() <= a0 || act_q[a0][16] !== 1'b1) begin
            n_fail++;
            $display("FAIL after_enable_sof: got first word %05h expected bit16=1",
                     (act_q.size() > a0) ? act_q[a0] : 17'h0);
        end
    endtask

    task automatic test_overflow();
        run_frame(2, 4, 4, 0, 0, 0, 1'b0, 1'b1, "overflow_first");
        run_frame(2, 4, 4, 0, 0, 0, 1'b0, 1'b0, "overflow_cleared");
    endtask

    task automatic test_bad_geometry();
        run_frame(2, 6, 4, 0, 0, 0, 1'b0, 1'b0, "long_line");
        run_frame(2, 5, 4, 0, 0, 0, 1'b0, 1'b0, "odd_bytes");
        run_frame(2, 4, 4, 0, 0, 0, 1'b0, 1'b0, "recover");
        run_frame(1, 4, 0, 0, 0, 0, 1'b0, 1'b0, "short_frame");
    endtask

    task automatic test_vsync_edges();
        run_frame(2, 4, 4, 0, 1, 0, 1'b0, 1'b0, "href_fall_at_vsync");
        run_frame(3, 4, 4, 4, 2, 0, 1'b0, 1'b0, "write_at_vsync");
        run_frame(2, 4, 4, 0, 2, 0, 1'b0, 1'b0, "write_at_vsync_short");
    endtask

    task automatic test_disable_mid_pixel();
        int a0, d0, e0;
        a0 = act_q.size(); d0 = done_cnt; e0 = err_cnt;
        repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 8'h12, 1'b0);
        cyc(1'b0, 1'b1, 8'h34, 1'b0);
        enable = 1'b0;
        cyc(1'b0, 1'b1, 8'h56, 1'b0);
        cyc(1'b0, 1'b1, 8'h78, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b0);
        enable = 1'b1;
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (5) cyc(1'b1, 1'b0, 8'h00, 1'b0);
        n_checks++;
        if (act_q.size() != a0 || done_cnt != d0 || err_cnt != e0) begin
            n_fail++;
            $display("FAIL disable_mid_pixel_quiet: got writes=%0d pulses=%0d expected 0 and 0",
                     act_q.size() - a0, (done_cnt - d0) + (err_cnt - e0));
        end
        run_frame(2, 4, 4, 0, 0, 0, 1'b0, 1'b0, "after_reenable");
    endtask

    task automatic test_random();
        int nl, len[3];
        for (int n = 0; n < 16; n++) begin
            nl = $urandom_range(1, 3);
            for (int i = 0; i < 3; i++)
                len[i] = ($urandom_range(0, 2) != 0) ? 2 * W : $urandom_range(3, 6);
            run_frame(nl, len[0], len[1], len[2], $urandom_range(0, 2), 25, 1'b0, 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_enable_mid_frame();
        test_overflow();
        test_bad_geometry();
        test_vsync_edges();
        test_disable_mid_pixel();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
